if_id_queue: RTL
================

// Module: if_id_queue
// PURPOSE
//  Instruction queue between the fetch stage and decode. Buffers {PC, instruction}
//  pairs with a valid/ready handshake on both sides. Fetch pushes every fetched word;
//  decode pops at its own rate. A flush discards all buffered words on a redirect
//  (j/jal/jr).
// PARAMETERS
//  DEPTH    4   number of entries; power of two, >= 2
//  PC_W     10  PC width (word address)
//  INSTR_W  32  instruction width
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              asynchronous reset, active-high
//  flush      in   1              discard all entries (synchronous)
//  in_valid   in   1              fetch presents a word
//  in_ready   out  1              queue accepts a word this cycle
//  in_pc      in   PC_W           PC of the presented word
//  in_instr   in   INSTR_W        presented instruction
//  out_valid  out  1              head entry available to decode
//  out_ready  in   1              decode consumes the head this cycle
//  out_pc     out  PC_W           PC of the head entry
//  out_instr  out  INSTR_W        head instruction
//  count      out  clog2(DEPTH)+1 number of occupied entries
// BEHAVIOUR
//  - Reset (async, rst=1): wr_ptr=rd_ptr=0, count=0, out_valid=0, out_pc=0,
//    out_instr=0. Storage contents are don't-care.
//  - push = in_valid & in_ready; pop = out_valid & out_ready.
//  - in_ready = (count != DEPTH). Not dependent on out_ready, so no comb path.
//    A push into a full queue is not accepted, even when a pop occurs in the same cycle.
//  - out_valid = (count != 0). out_pc/out_instr = entry[rd_ptr] when valid,
//    otherwise all zeros (the instruction value is then a NOP).
//  - Latency: a word pushed in cycle N is visible at the output in cycle N+1.
//  - Push only: entry[wr_ptr] <= {in_pc,in_instr}, wr_ptr++, count++.
//    Pop only: rd_ptr++, count--. Push and pop together: both pointers advance and
//    count is unchanged. This also holds when count==1.
//  - Pointers are log2(DEPTH) bits wide and wrap modulo DEPTH naturally.
//  - Order is strictly FIFO. No entry is ever duplicated or reordered.
//  - Flush has highest priority. At the next edge: count=0, wr_ptr=rd_ptr=0, and
//    out_valid=0. A push or pop in the flush cycle has no effect (the word is
//    dropped). The handshake outputs are not masked combinationally during the
//    flush cycle.
//  - rst asserted mid-operation overrides flush and all traffic immediately.
//  - While fetch holds for jr, in_valid=0. The queue drains normally.
// CONFIGURATION
//  IF_ID_QUEUE_BYPASS_EN
//   defined: when count==0 and in_valid=1 and flush=0:
//     - out_valid=1 and out_pc/out_instr=in_pc/in_instr combinationally (0-cycle path).
//     - If out_ready=1 as well, the word is consumed directly and not written
//       (count stays 0).
//     - If out_ready=0, the word is written as a normal push.
//     - flush=1 suppresses the bypass (out_valid=0).
//   undefined: no bypass. Minimum latency is 1 cycle, with no comb path in->out.
// TESTING
//  1. Assert rst for 2 cycles, then release -> count=0, out_valid=0, in_ready=1,
//     out_instr=0.
//  2. Push PC 0..3 (instr 0x20010000+PC), out_ready=0 -> count=4, in_ready=0.
//     Then push PC 4 -> not accepted. Pop 4 times -> PC 0,1,2,3 in order.
//  3. count=2, in_valid=out_ready=1 for 10 cycles -> count stays 2. Pointers wrap
//     and output order is preserved.
//  4. count=3, flush=1 with in_valid=1 (PC 0x07F) -> next cycle count=0,
//     out_valid=0, and PC 0x07F is never output.
//  5. Assert rst asynchronously between clock edges with count=2 -> count=0 and
//     out_valid=0 immediately, without waiting for a clock edge.
//  6. Bypass on, empty, in_valid=out_ready=1, PC 0x010 -> out_valid=1 in the same
//     cycle with out_pc=0x010, and count stays 0. Bypass off -> out_pc=0x010
//     appears one cycle later.

Source files
------------

// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of {pc, instr} with valid/ready on both sides and flush.
// Optional IF_ID_QUEUE_BYPASS_EN adds a zero-cycle path from input to output when the queue is empty.
module if_id_queue #(
  parameter int DEPTH   = 4,
  parameter int PC_W    = 10,
  parameter int INSTR_W = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [INSTR_W-1:0]       in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [INSTR_W-1:0]       out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [PC_W-1:0]    pc_mem    [DEPTH];
  logic [INSTR_W-1:0] instr_mem [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;

  logic push, pop, bypass, bypass_take, wr_en, rd_en;

  always_comb begin
    in_ready = (count != FULL);
`ifdef IF_ID_QUEUE_BYPASS_EN
    bypass = (count == '0) && in_valid && !flush;
`else
    bypass = 1'b0;
`endif
    out_valid = (count != '0) || bypass;
    out_pc    = '0;
    out_instr = '0;
    if (bypass) begin
      out_pc    = in_pc;
      out_instr = in_instr;
    end else if (count != '0) begin
      out_pc    = pc_mem[rd_ptr];
      out_instr = instr_mem[rd_ptr];
    end
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    // A bypassed word consumed in the same cycle never touches storage.
    bypass_take = bypass && out_ready;
    wr_en       = push && !bypass_take;
    rd_en       = pop && !bypass_take;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (wr_en && !rd_en)
        count <= count + 1'b1;
      else if (!wr_en && rd_en)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !flush) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
    end
  end

endmodule
